fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//   Downstream drain stage for the 8x8 synchronous fifo. Pops words via rd_en/empty,
//   absorbs the fifo's one-cycle read latency, and presents them on a valid/ready stream.
//   A 2-entry skid buffer sustains 1 word/clock with no drop or duplication under backpressure.
//   Counts delivered words for debug/status.
// PARAMETERS
//   WIDTH  8   data width; equals the fifo WIDTH
//   CNT_W  16  width of words_out counter
// PORTS
//   clock      in   1      single clock, rising edge
//   reset      in   1      asynchronous, active-low; the fifo is reset from the same source
//   fifo_empty in   1      fifo empty flag
//   fifo_data  in   WIDTH  fifo data_out; valid the cycle after a sampled rd_en
//   fifo_rd_en out  1      pop request to the fifo (fifo rd_en)
//   m_valid    out  1      stream word valid
//   m_ready    in   1      stream consumer ready
//   m_data     out  WIDTH  stream word (buffer head)
//   words_out  out  CNT_W  words accepted by consumer (m_valid&&m_ready), wraps mod 2^CNT_W
// BEHAVIOUR
//   Reset (reset==0, async, takes effect immediately):
//     count=0, in_flight=0, m_valid=0, m_data=0, words_out=0, fifo_rd_en=0.
//   State: buffer count (0..2); in_flight (1 = read issued last edge, data arrives this cycle).
//   fifo_rd_en = reset && !fifo_empty && (count + in_flight - pop) < 2, with pop = m_valid&&m_ready.
//     Combinational path m_ready -> fifo_rd_en is intentional and gives full throughput.
//   in_flight <= fifo_rd_en each edge.
//   Capture: when in_flight==1, fifo_data is written to buffer tail at the rising edge.
//   Pop: when m_valid&&m_ready, head is removed at the edge; words_out += 1 (wraps).
//   Capture and pop on the same edge: count is unchanged; order preserved (FIFO order).
//   m_valid = (count != 0); m_data = head entry (registered, no fifo_data bypass).
//   Latency: rd_en high at edge N -> word in buffer at edge N+1 -> m_valid high after N+1.
//   Once m_valid rises, m_data is stable until popped (held under m_ready=0).
//   count never exceeds 2 and never goes below 0; overflow/underflow is a design error
//     (assertion in bench).
//   No read is issued while fifo_empty==1; an empty fifo simply lets the buffer drain.
//   Reset mid-operation: buffered and in-flight words are discarded; the fifo is reset
//     with this block, so no pointer mismatch arises.
// TESTING
//   1 Hold reset=0 for 2 clocks with fifo non-empty -> fifo_rd_en=0, m_valid=0,
//     m_data=0, words_out=0.
//   2 Write 7 words 0x11..0x17 into fifo, m_ready=1 -> fifo_rd_en high 7 consecutive
//     cycles; m_data 0x11..0x17 back-to-back, 1 cycle after each read; words_out=7;
//     fifo_rd_en=0 once empty.
//   3 Fifo holds 5 words, m_ready=0 -> exactly 2 reads issued, then fifo_rd_en=0;
//     m_data holds 0x11; raise m_ready -> 0x11..0x15 in order, none lost.
//   4 m_ready toggling 1,0,1,0 over 7 words -> each word seen exactly once in order;
//     words_out=7; count<=2 throughout.
//   5 reset pulsed low mid-stream with count=2 -> m_valid, m_data, words_out drop to 0
//     before the next clock edge; after release, refill and stream resume cleanly.
//   6 CNT_W=4, stream 17 words -> words_out wraps 15->0->1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Drain stage for the 8x8 synchronous fifo: pops words, absorbs the one-cycle read
// latency in a 2-entry skid buffer, and presents them on a valid/ready stream.
`timescale 1ns/1ps
module fifo_rd_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] words_out
);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    buf_state_t       r_state;
    logic             r_in_flight;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [CNT_W-1:0] r_words;

    logic             w_pop;
    logic [2:0]       w_occ;

    assign m_valid   = (r_state != BUF_EMPTY);
    assign m_data    = r_head;
    assign words_out = r_words;
    assign w_pop     = m_valid && m_ready;

    // Occupancy after this edge; including the pop lets a read issue while the
    // buffer is full but draining, which is what sustains one word per clock.
    assign w_occ      = {1'b0, r_state} + {2'b00, r_in_flight} - {2'b00, w_pop};
    assign fifo_rd_en = reset && !fifo_empty && (w_occ < 3'd2);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= BUF_EMPTY;
            r_in_flight <= 1'b0;
            r_head      <= '0;
            r_tail      <= '0;
            r_words     <= '0;
        end else begin
            r_in_flight <= fifo_rd_en;
            if (w_pop) begin
                r_words <= r_words + CNT_W'(1);
            end
            if (r_in_flight && !w_pop) begin
                if (r_state == BUF_EMPTY) begin
                    r_head  <= fifo_data;
                    r_state <= BUF_ONE;
                end else if (r_state == BUF_ONE) begin
                    r_tail  <= fifo_data;
                    r_state <= BUF_TWO;
                end
            end else if (!r_in_flight && w_pop) begin
                if (r_state == BUF_TWO) begin
                    r_head  <= r_tail;
                    r_state <= BUF_ONE;
                end else begin
                    r_state <= BUF_EMPTY;
                end
            end else if (r_in_flight && w_pop) begin
                // Simultaneous capture and pop: occupancy holds, head advances.
                if (r_state == BUF_TWO) begin
                    r_head <= r_tail;
                    r_tail <= fifo_data;
                end else begin
                    r_head <= fifo_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a behavioural 8x8 fifo feeds the DUT and
// accepted stream words are logged and compared against hand-computed values.
`timescale 1ns/1ps
module tb_fifo_rd_stream;

    logic        clock = 1'b0;
    logic        reset;
    logic        f_rst_n;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [15:0] words_out;

    logic        rd_en4;
    logic        m_valid4;
    logic [7:0]  m_data4;
    logic [3:0]  words_out4;

    logic        f_wr;
    logic [7:0]  f_din;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .words_out  (words_out)
    );

    fifo_rd_stream #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (rd_en4),
        .m_valid    (m_valid4),
        .m_ready    (m_ready),
        .m_data     (m_data4),
        .words_out  (words_out4)
    );

    // Behavioural 8x8 fifo with registered data_out (one-cycle read latency).
    logic [7:0] f_mem [0:7];
    logic [2:0] f_wp, f_rp;
    logic [3:0] f_cnt;
    logic       f_do_rd, f_do_wr;

    assign f_do_rd    = fifo_rd_en && (f_cnt != 4'd0);
    assign f_do_wr    = f_wr && ((f_cnt != 4'd8) || f_do_rd);
    assign fifo_empty = (f_cnt == 4'd0);

    always @(posedge clock or negedge f_rst_n) begin
        if (!f_rst_n) begin
            f_wp      <= 3'd0;
            f_rp      <= 3'd0;
            f_cnt     <= 4'd0;
            fifo_data <= 8'd0;
        end else begin
            if (f_do_rd) begin
                fifo_data <= f_mem[f_rp];
                f_rp      <= f_rp + 3'd1;
            end
            if (f_do_wr) begin
                f_mem[f_wp] <= f_din;
                f_wp        <= f_wp + 3'd1;
            end
            f_cnt <= f_cnt + {3'b000, f_do_wr} - {3'b000, f_do_rd};
        end
    end

    // Stream and read monitors.
    int         cyc = 0;
    int         n_acc, n_rd, rd_run, rd_maxrun, first_rd_cyc;
    logic [7:0] acc_log [0:63];
    int         acc_cyc [0:63];

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_acc        <= 0;
            n_rd         <= 0;
            rd_run       <= 0;
            rd_maxrun    <= 0;
            first_rd_cyc <= -1;
        end else begin
            if (m_valid && m_ready && n_acc < 64) begin
                acc_log[n_acc] <= m_data;
                acc_cyc[n_acc] <= cyc;
                n_acc          <= n_acc + 1;
            end
            if (fifo_rd_en) begin
                if (n_rd == 0) first_rd_cyc <= cyc;
                n_rd   <= n_rd + 1;
                rd_run <= rd_run + 1;
                if (rd_run + 1 > rd_maxrun) rd_maxrun <= rd_run + 1;
            end else begin
                rd_run <= 0;
            end
        end
    end

    // Independent occupancy model: words in flight land one edge after the read.
    int   occ;
    logic prev_rd;
    logic occ_bad = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            occ     <= 0;
            prev_rd <= 1'b0;
        end else begin
            occ     <= occ + int'(prev_rd) - int'(m_valid && m_ready);
            prev_rd <= fifo_rd_en;
        end
    end

    always @(negedge clock) begin
        if (reset === 1'b1 && (occ > 2 || occ < 0 || m_valid !== (occ != 0)))
            occ_bad <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        f_wr  = 1'b1;
        f_din = d;
        @(negedge clock);
        f_wr  = 1'b0;
    endtask

    task automatic wait_acc(input int target, input string tag);
        int t;
        t = 0;
        while (n_acc < target && t < 200) begin
            @(negedge clock);
            t++;
        end
        chk(tag, n_acc, target);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset   = 1'b0;
        f_rst_n = 1'b0;
        m_ready = 1'b0;
        f_wr    = 1'b0;
        f_din   = 8'd0;

        // 1: DUT held in reset while the fifo has data.
        @(negedge clock);
        f_rst_n = 1'b1;
        push(8'hA5);
        @(negedge clock);
        @(negedge clock);
        chk("rst_fifo_nonempty", fifo_empty, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_words", words_out, 0);
        f_rst_n = 1'b0;
        @(negedge clock);
        reset   = 1'b1;
        f_rst_n = 1'b1;

        // 2: seven words streamed at full rate.
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) push(8'h11 + 8'(i));
        wait_acc(7, "t2_count");
        for (int i = 0; i < 7; i++) chk($sformatf("t2_data%0d", i), acc_log[i], 8'h11 + 8'(i));
        chk("t2_latency", acc_cyc[0] - first_rd_cyc, 2);
        chk("t2_back_to_back", acc_cyc[6] - acc_cyc[0], 6);
        chk("t2_reads", n_rd, 7);
        chk("t2_read_run", rd_maxrun, 7);
        chk("t2_words", words_out, 7);
        @(negedge clock);
        @(negedge clock);
        chk("t2_rd_idle", fifo_rd_en, 0);
        chk("t2_valid_idle", m_valid, 0);

        // 3: backpressure stops reads at two buffered words.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        repeat (4) @(negedge clock);
        chk("t3_reads", n_rd, 9);
        chk("t3_rd_stall", fifo_rd_en, 0);
        chk("t3_fifo_holds", fifo_empty, 0);
        chk("t3_valid", m_valid, 1);
        chk("t3_head", m_data, 8'h11);
        @(negedge clock);
        chk("t3_head_held", m_data, 8'h11);
        m_ready = 1'b1;
        wait_acc(12, "t3_count");
        for (int i = 0; i < 5; i++) chk($sformatf("t3_data%0d", i), acc_log[7 + i], 8'h11 + 8'(i));
        chk("t3_words", words_out, 12);
        chk("t3_reads_total", n_rd, 12);

        // 4: consumer ready toggling every cycle.
        for (int i = 0; i < 7; i++) begin
            f_wr    = 1'b1;
            f_din   = 8'h21 + 8'(i);
            m_ready = (i % 2 == 0);
            @(negedge clock);
        end
        f_wr = 1'b0;
        for (int t = 0; t < 100 && n_acc < 19; t++) begin
            m_ready = ~m_ready;
            @(negedge clock);
        end
        chk("t4_count", n_acc, 19);
        for (int i = 0; i < 7; i++) chk($sformatf("t4_data%0d", i), acc_log[12 + i], 8'h21 + 8'(i));
        chk("t4_words", words_out, 19);
        chk("t4_occupancy", occ_bad, 0);

        // 5: asynchronous reset with a full buffer.
        m_ready = 1'b0;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        repeat (4) @(negedge clock);
        chk("t5_valid_full", m_valid, 1);
        chk("t5_head_full", m_data, 8'h31);
        chk("t5_rd_stall", fifo_rd_en, 0);
        #2;
        reset   = 1'b0;
        f_rst_n = 1'b0;
        #1;
        chk("t5_async_valid", m_valid, 0);
        chk("t5_async_data", m_data, 0);
        chk("t5_async_words", words_out, 0);
        chk("t5_async_rd_en", fifo_rd_en, 0);
        #1;
        reset   = 1'b1;
        f_rst_n = 1'b1;
        @(negedge clock);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
        wait_acc(4, "t5_count");
        for (int i = 0; i < 4; i++) chk($sformatf("t5_data%0d", i), acc_log[i], 8'h41 + 8'(i));
        chk("t5_words", words_out, 4);
        repeat (3) @(negedge clock);
        chk("t5_no_extra", n_acc, 4);
        chk("t5_drained", m_valid, 0);

        // 6: 4-bit counter wraps after 16 accepted words.
        reset   = 1'b0;
        f_rst_n = 1'b0;
        @(negedge clock);
        reset   = 1'b1;
        f_rst_n = 1'b1;
        chk("t6_w4_reset", words_out4, 0);
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
        m_ready = 1'b1;
        wait_acc(8, "t6_count8");
        chk("t6_w4_8", words_out4, 8);
        for (int i = 8; i < 15; i++) push(8'h50 + 8'(i));
        wait_acc(15, "t6_count15");
        chk("t6_w4_15", words_out4, 15);
        chk("t6_w16_15", words_out, 15);
        push(8'h5F);
        wait_acc(16, "t6_count16");
        chk("t6_w4_wrap0", words_out4, 0);
        chk("t6_w16_16", words_out, 16);
        push(8'h60);
        wait_acc(17, "t6_count17");
        chk("t6_w4_wrap1", words_out4, 1);
        for (int i = 0; i < 17; i++) chk($sformatf("t6_data%0d", i), acc_log[i], 8'h50 + 8'(i));
        chk("t6_occupancy", occ_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
